// File: rtl/wb_dma_ch_sched.sv
// -----------------------------------------------------------------------------
// wb_dma_ch_sched
//
// Picks which DMA channel owns the shared Wishbone master datapath. Channels
// at the highest requesting priority share the datapath in round-robin order.
// An optional beat quota forces re-arbitration so that no channel can hold the
// datapath indefinitely.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   req        per-channel level request, held until serviced
//   pri        priority of channel i in bits [i*PRI_W +: PRI_W]; larger wins
//   advance    current owner finished its transfer; release the grant
//   beat       one data beat completed by the current owner
//   gnt        index of the granted channel (registered)
//   gnt_oh     one-hot of gnt, all zero while gnt_vld is low (registered)
//   gnt_vld    a grant is active (registered)
//   quota_hit  one-cycle pulse: the previous grant was ended by the quota
// -----------------------------------------------------------------------------
module wb_dma_ch_sched #(
    parameter int CH_NUM = 8,
    parameter int CH_W   = 3,
    parameter int PRI_W  = 3,
    parameter int QUOTA  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       req,
    input  logic [CH_NUM*PRI_W-1:0] pri,
    input  logic                    advance,
    input  logic                    beat,
    output logic [CH_W-1:0]         gnt,
    output logic [CH_NUM-1:0]       gnt_oh,
    output logic                    gnt_vld,
    output logic                    quota_hit
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam int BCW = (QUOTA > 0) ? $clog2(QUOTA + 1) : 1;
    localparam int QUOTA_LAST_I = (QUOTA > 0) ? QUOTA - 1 : 0;
    localparam logic [BCW-1:0]    QUOTA_LAST = QUOTA_LAST_I[BCW-1:0];
    localparam logic [CH_NUM-1:0] OH_ONE     = {{(CH_NUM-1){1'b0}}, 1'b1};
    localparam int RR_RST_I = CH_NUM - 1;
    localparam logic [CH_W-1:0]   RR_RST     = RR_RST_I[CH_W-1:0];

    state_e             state_q, state_d;
    logic [CH_W-1:0]    gnt_q, gnt_d;
    logic [CH_NUM-1:0]  gnt_oh_q, gnt_oh_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               quota_hit_q, quota_hit_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;

    // Winner evaluation
    logic [CH_W-1:0]    ptr_eval;
    logic [PRI_W-1:0]   maxp;
    logic [CH_NUM-1:0]  cand;
    logic [CH_W-1:0]    winner;
    logic               found;
    logic               any_req;
    int                 idx;

    logic               quota_rel;
    logic               release_now;

    // While a grant is active, re-arbitration always starts just after the
    // current owner, so a release sees the pointer already advanced to gnt.
    assign ptr_eval = (state_q == GRANT) ? gnt_q : rr_ptr_q;
    assign any_req  = |req;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        maxp   = '0;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Only requesting channels contribute to the level being served.
        for (int i = 0; i < CH_NUM; i++) begin
            if (req[i] && (pri[i*PRI_W +: PRI_W] > maxp)) begin
                maxp = pri[i*PRI_W +: PRI_W];
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            cand[i] = req[i] && (pri[i*PRI_W +: PRI_W] == maxp);
        end
        // Scan ptr+1 .. ptr+CH_NUM with wrap; the pointer channel comes last.
        for (int k = 1; k <= CH_NUM; k++) begin
            idx = int'(ptr_eval) + k;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            if (!found && cand[idx]) begin
                winner = idx[CH_W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign quota_rel   = (QUOTA != 0) && beat && (beat_cnt_q == QUOTA_LAST);
    assign release_now = advance || !req[gnt_q] || quota_rel;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_oh_d    = gnt_oh_q;
        gnt_vld_d   = gnt_vld_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        quota_hit_d = 1'b0;

        case (state_q)
            IDLE: begin
                // advance and beat have no owner to act on here.
                if (any_req) begin
                    state_d    = GRANT;
                    gnt_d      = winner;
                    gnt_oh_d   = OH_ONE << winner;
                    gnt_vld_d  = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_d    = gnt_q;
                    quota_hit_d = quota_rel;
                    beat_cnt_d  = '0;
                    if (any_req) begin
                        // Hand over with no idle bubble.
                        gnt_d    = winner;
                        gnt_oh_d = OH_ONE << winner;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_oh_d  = '0;
                        gnt_vld_d = 1'b0;
                    end
                end else if ((QUOTA != 0) && beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_oh_q    <= '0;
            gnt_vld_q   <= 1'b0;
            quota_hit_q <= 1'b0;
            rr_ptr_q    <= RR_RST;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_oh_q    <= gnt_oh_d;
            gnt_vld_q   <= gnt_vld_d;
            quota_hit_q <= quota_hit_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_oh    = gnt_oh_q;
    assign gnt_vld   = gnt_vld_q;
    assign quota_hit = quota_hit_q;

endmodule

// File: tb/tb_wb_dma_ch_sched.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_ch_sched
//
// Directed bench for wb_dma_ch_sched. Two instances share all inputs: one with
// unlimited grants (QUOTA=0) and one with QUOTA=4. Grant state is compared as
// the packed triple {gnt_vld, gnt, gnt_oh}.
// -----------------------------------------------------------------------------
module tb_wb_dma_ch_sched;

    localparam int CH_NUM = 8;
    localparam int CH_W   = 3;
    localparam int PRI_W  = 3;

    logic                    clk;
    logic                    rst;
    logic [CH_NUM-1:0]       req;
    logic [CH_NUM*PRI_W-1:0] pri;
    logic                    advance;
    logic                    beat;

    logic [CH_W-1:0]   gnt_a,    gnt_b;
    logic [CH_NUM-1:0] gnt_oh_a, gnt_oh_b;
    logic              vld_a,    vld_b;
    logic              qh_a,     qh_b;

    int checks = 0;
    int errors = 0;

    wb_dma_ch_sched #(.CH_NUM(CH_NUM), .CH_W(CH_W), .PRI_W(PRI_W), .QUOTA(0)) u_dut (
        .clk(clk), .rst(rst), .req(req), .pri(pri), .advance(advance), .beat(beat),
        .gnt(gnt_a), .gnt_oh(gnt_oh_a), .gnt_vld(vld_a), .quota_hit(qh_a)
    );

    wb_dma_ch_sched #(.CH_NUM(CH_NUM), .CH_W(CH_W), .PRI_W(PRI_W), .QUOTA(4)) u_dut_q4 (
        .clk(clk), .rst(rst), .req(req), .pri(pri), .advance(advance), .beat(beat),
        .gnt(gnt_b), .gnt_oh(gnt_oh_b), .gnt_vld(vld_b), .quota_hit(qh_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        req     = '0;
        pri     = '0;
        advance = 1'b0;
        beat    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a, qh_a} !== 13'h0) begin
            errors++;
            $display("FAIL reset_q0: got vld=%0b gnt=%0d oh=%02h qh=%0b required all 0",
                     vld_a, gnt_a, gnt_oh_a, qh_a);
        end
        checks++;
        if ({vld_b, gnt_b, gnt_oh_b, qh_b} !== 13'h0) begin
            errors++;
            $display("FAIL reset_q4: got vld=%0b gnt=%0d oh=%02h qh=%0b required all 0",
                     vld_b, gnt_b, gnt_oh_b, qh_b);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp [3];
        exp[0] = {1'b1, 3'd0, 8'h01};
        exp[1] = {1'b1, 3'd2, 8'h04};
        exp[2] = {1'b1, 3'd0, 8'h01};
        do_reset();
        req = 8'h05;
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL rr_latency: got vld=%0b before edge, required 0", vld_a);
        end
        tick();
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                advance = 1'b1;
                tick();
                advance = 1'b0;
            end
            checks++;
            if ({vld_a, gnt_a, gnt_oh_a} !== exp[s]) begin
                errors++;
                $display("FAIL rr_step%0d: got vld=%0b gnt=%0d oh=%02h required %03h",
                         s, vld_a, gnt_a, gnt_oh_a, exp[s]);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        req = 8'hFF;
        pri = 24'd3 << (5 * PRI_W);
        tick();
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                advance = 1'b1;
                tick();
                advance = 1'b0;
            end
            checks++;
            if ({vld_a, gnt_a, gnt_oh_a} !== {1'b1, 3'd5, 8'h20}) begin
                errors++;
                $display("FAIL pri_hold%0d: got vld=%0b gnt=%0d oh=%02h required gnt=5",
                         s, vld_a, gnt_a, gnt_oh_a);
            end
        end
        req = 8'hDF;
        tick();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a} !== {1'b1, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL pri_withdraw: got vld=%0b gnt=%0d oh=%02h required gnt=6",
                     vld_a, gnt_a, gnt_oh_a);
        end
    endtask

    task automatic test_quota();
        logic [CH_W-1:0] g_before [3];
        logic [CH_W-1:0] g_after  [3];
        g_before[0] = 3'd1; g_after[0] = 3'd2;
        g_before[1] = 3'd2; g_after[1] = 3'd1;
        g_before[2] = 3'd1; g_after[2] = 3'd2;
        do_reset();
        req = 8'h06;
        tick();
        for (int r = 0; r < 3; r++) begin
            beat = 1'b1;
            tick();
            tick();
            tick();
            checks++;
            if ({vld_b, gnt_b, qh_b} !== {1'b1, g_before[r], 1'b0}) begin
                errors++;
                $display("FAIL quota_r%0d_3beats: got vld=%0b gnt=%0d qh=%0b required gnt=%0d qh=0",
                         r, vld_b, gnt_b, qh_b, g_before[r]);
            end
            // Third round: advance coincides with the quota-ending beat.
            if (r == 2) advance = 1'b1;
            tick();
            beat    = 1'b0;
            advance = 1'b0;
            checks++;
            if ({vld_b, gnt_b, qh_b} !== {1'b1, g_after[r], 1'b1}) begin
                errors++;
                $display("FAIL quota_r%0d_hit: got vld=%0b gnt=%0d qh=%0b required gnt=%0d qh=1",
                         r, vld_b, gnt_b, qh_b, g_after[r]);
            end
            tick();
            checks++;
            if ({gnt_b, qh_b} !== {g_after[r], 1'b0}) begin
                errors++;
                $display("FAIL quota_r%0d_pulse: got gnt=%0d qh=%0b required gnt=%0d qh=0",
                         r, gnt_b, qh_b, g_after[r]);
            end
        end
        // Same beats on the unlimited instance must never move its grant.
        checks++;
        if ({vld_a, gnt_a, qh_a} !== {1'b1, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL quota_unlimited: got vld=%0b gnt=%0d qh=%0b required gnt=2 qh=0",
                     vld_a, gnt_a, qh_a);
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        req = 8'h08;
        tick();
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                advance = 1'b1;
                tick();
                advance = 1'b0;
            end
            checks++;
            if ({vld_a, gnt_a, gnt_oh_a, qh_a} !== {1'b1, 3'd3, 8'h08, 1'b0}) begin
                errors++;
                $display("FAIL sole_%0d: got vld=%0b gnt=%0d oh=%02h qh=%0b required gnt=3 vld=1 qh=0",
                         s, vld_a, gnt_a, gnt_oh_a, qh_a);
            end
        end
    endtask

    task automatic test_release_idle();
        do_reset();
        req = 8'h10;
        tick();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a} !== {1'b1, 3'd4, 8'h10}) begin
            errors++;
            $display("FAIL idle_grant: got vld=%0b gnt=%0d oh=%02h required gnt=4",
                     vld_a, gnt_a, gnt_oh_a);
        end
        req = 8'h00;
        tick();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a} !== 12'h0) begin
            errors++;
            $display("FAIL idle_drop: got vld=%0b gnt=%0d oh=%02h required all 0",
                     vld_a, gnt_a, gnt_oh_a);
        end
        advance = 1'b1;
        beat    = 1'b1;
        tick();
        tick();
        advance = 1'b0;
        beat    = 1'b0;
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a, vld_b, qh_b} !== 14'h0) begin
            errors++;
            $display("FAIL idle_ignore: got vld=%0b gnt=%0d oh=%02h vld_q4=%0b qh_q4=%0b required all 0",
                     vld_a, gnt_a, gnt_oh_a, vld_b, qh_b);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'hC0;
        tick();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a} !== {1'b1, 3'd6, 8'h40}) begin
            errors++;
            $display("FAIL rst_pre: got vld=%0b gnt=%0d oh=%02h required gnt=6",
                     vld_a, gnt_a, gnt_oh_a);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a, qh_a} !== 13'h0) begin
            errors++;
            $display("FAIL rst_async: got vld=%0b gnt=%0d oh=%02h qh=%0b required all 0",
                     vld_a, gnt_a, gnt_oh_a, qh_a);
        end
        req = 8'hC1;
        tick();
        rst = 1'b1;
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_held: got vld=%0b required 0", vld_a);
        end
        tick();
        checks++;
        if ({vld_a, gnt_a, gnt_oh_a} !== {1'b1, 3'd0, 8'h01}) begin
            errors++;
            $display("FAIL rst_restart: got vld=%0b gnt=%0d oh=%02h required gnt=0",
                     vld_a, gnt_a, gnt_oh_a);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_quota();
        test_sole_requester();
        test_release_idle();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dma_ch_sched.md
Name: wb_dma_ch_sched

Overview:
- Priority-aware round-robin channel scheduler for the DMA engine.
- Sits between the per-channel request logic and the shared Wishbone master datapath. It picks one channel at a time to own the datapath.
- Arbitration is strict priority across levels and round-robin within the highest requesting level.
- An optional beat quota forces re-arbitration so that no channel can hold the datapath indefinitely.

Parameters:
CH_NUM, 8, number of requesting channels (2..31)
CH_W, 3, width of grant index; must equal clog2(CH_NUM)
PRI_W, 3, per-channel priority width; larger value means higher priority
QUOTA, 0, max data beats per grant; 0 means unlimited

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req  input  CH_NUM  per-channel request, level, held until serviced
pri  input  CH_NUM*PRI_W  priority of channel i in bits [i*PRI_W +: PRI_W]
advance  input  1  current owner finished its transfer; release grant
beat  input  1  one data beat completed by the current owner
gnt  output  CH_W  index of granted channel, registered
gnt_oh  output  CH_NUM  one-hot of gnt, all zero when gnt_vld=0, registered
gnt_vld  output  1  a grant is active, registered
quota_hit  output  1  one-cycle pulse: previous grant ended by quota

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0, gnt_oh=0, gnt_vld=0, quota_hit=0.
  - rr_ptr=CH_NUM-1, so channel 0 wins the first tie.
  - beat_cnt=0.
- Winner function (combinational, on the current req/pri):
  - maxp = max pri[i] over i with req[i]=1.
  - cand = req & (pri==maxp).
  - winner = first set bit of cand scanning rr_ptr+1, rr_ptr+2, … modulo CH_NUM (wrap-around).
  - any = |req.
- IDLE:
  - gnt_vld=0; advance and beat are ignored.
  - If any: at the next edge go to GRANT, with gnt=winner, gnt_oh=1<<winner, gnt_vld=1, beat_cnt=0.
  - Latency from req sampled high to gnt_vld high is 1 cycle.
- GRANT:
  - gnt and gnt_oh are stable until a release edge.
  - On beat=1, beat_cnt increments.
  - A release occurs on an edge where any of these holds:
    - advance=1;
    - req[gnt]=0 (owner withdrew);
    - QUOTA!=0 and beat=1 and beat_cnt==QUOTA-1.
  - On release, rr_ptr<=gnt, and the winner is evaluated against rr_ptr=gnt in the same cycle:
    - If any: stay in GRANT, load the new winner, beat_cnt=0. Back-to-back with no bubble.
    - Else: go to IDLE; gnt_vld=0 next cycle, gnt/gnt_oh cleared.
- Winner selection is round-robin, so the same channel is re-granted only if it is the sole requester at maxp. In that case gnt is unchanged, gnt_vld stays 1, and beat_cnt is reset.
- Priority or req changes on non-owners never preempt an active grant.
- quota_hit is 1 in the cycle after a release caused by quota, including when advance occurs on the same edge. It is 0 otherwise.
- Simultaneous advance, withdrawal and quota on one edge count as a single release.
- beat_cnt width is clog2(QUOTA+1), minimum 1. It is unused when QUOTA=0.
- Reset asserted mid-grant: all outputs go to reset values immediately. After reset release, arbitration restarts from rr_ptr=CH_NUM-1.
- Out-of-range priorities are impossible by width. Channels with req=0 never win, regardless of pri.

Test Plan:
1. Round-robin (QUOTA=0):
   - Stimulus: after reset, req=8'h05, all pri=0.
   - Required: cycle+1 gnt=0, gnt_vld=1. Pulse advance: gnt=2. Pulse advance: gnt=0. gnt_oh tracks gnt each time.
2. Priority:
   - Stimulus: req=8'hFF, pri[5]=3, others 0.
   - Required: gnt=5. Repeated advance keeps gnt=5 with gnt_vld=1. Drop req[5]: next cycle gnt=6.
3. Quota (QUOTA=4):
   - Stimulus: req=8'h06, equal pri, 4 beat pulses while gnt=1.
   - Required: edge after 4th beat gives gnt=2. quota_hit=1 for exactly that cycle. beat_cnt restarts at 0.
4. Sole requester:
   - Stimulus: req=8'h08, advance pulsed 3 times.
   - Required: gnt stays 3, gnt_vld never drops, quota_hit stays 0.
5. Release to idle:
   - Stimulus: gnt=4, only req[4]=1, then req[4] drops.
   - Required: next cycle gnt_vld=0, gnt_oh=0. advance and beat in IDLE have no effect.
6. Reset mid-grant:
   - Stimulus: gnt=6 active, rst=0 asynchronously, then release reset with req=8'hC1.
   - Required: outputs go to 0 immediately, before the next clock edge. First post-reset grant is gnt=0.
